// File: rtl/worley_point_animator.sv
// Feature-point animator for the Worley noise stage.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for an unfrozen frame_tick; outputs hold
// ST_UPDATE | one point per cycle moved/reflected into the shadow set
// ST_COMMIT | shadow positions copied to pts_x/pts_y, frame_cnt bumped
//
// The shadow set is the working copy (positions and velocities). The live
// pts_x/pts_y registers only change on the commit edge, so a consumer never
// observes a half-updated frame.
module worley_point_animator #(
    parameter int NPTS  = 4,
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    parameter int VEL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               freeze,
    output logic [NPTS*XW-1:0] pts_x,
    output logic [NPTS*YW-1:0] pts_y,
    output logic               busy,
    output logic [19:0]        frame_cnt
);

    localparam int IDX_W = (NPTS > 1) ? $clog2(NPTS) : 1;

    localparam logic signed [XW+1:0] X_LIM   = (XW+2)'(X_MAX);
    localparam logic signed [XW+1:0] X_TWICE = (XW+2)'(2 * X_MAX);
    localparam logic signed [YW+1:0] Y_LIM   = (YW+2)'(Y_MAX);
    localparam logic signed [YW+1:0] Y_TWICE = (YW+2)'(2 * Y_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;

    logic [XW-1:0]      sh_x  [NPTS];
    logic [YW-1:0]      sh_y  [NPTS];
    logic [VEL_W-1:0]   sh_vx [NPTS];
    logic [VEL_W-1:0]   sh_vy [NPTS];

    logic signed [XW+1:0] nx;
    logic signed [XW+1:0] nx_ref;
    logic signed [YW+1:0] ny;
    logic signed [YW+1:0] ny_ref;
    logic [XW-1:0]        x_new;
    logic [YW-1:0]        y_new;
    logic [VEL_W-1:0]     vx_new;
    logic [VEL_W-1:0]     vy_new;

    // Seed table; indices beyond 3 reuse the four base seeds.
    function automatic logic [XW-1:0] seed_x(input int i);
        case (i % 4)
            0:       return XW'(100);
            1:       return XW'(300);
            2:       return XW'(500);
            default: return XW'(100);
        endcase
    endfunction

    function automatic logic [YW-1:0] seed_y(input int i);
        case (i % 4)
            0:       return YW'(100);
            1:       return YW'(200);
            2:       return YW'(400);
            default: return YW'(400);
        endcase
    endfunction

    function automatic logic [VEL_W-1:0] seed_vx(input int i);
        case (i % 4)
            0:       return VEL_W'(1);
            1:       return VEL_W'(-1);
            2:       return VEL_W'(2);
            default: return VEL_W'(-1);
        endcase
    endfunction

    function automatic logic [VEL_W-1:0] seed_vy(input int i);
        case (i % 4)
            0:       return VEL_W'(-1);
            1:       return VEL_W'(1);
            2:       return VEL_W'(-1);
            default: return VEL_W'(-2);
        endcase
    endfunction

    assign busy = (state != ST_IDLE);

    // Shared adder/reflector: moves the point selected by idx, both axes at once.
    always_comb begin
        nx     = $signed({2'b00, sh_x[idx]})
               + $signed({{(XW+2-VEL_W){sh_vx[idx][VEL_W-1]}}, sh_vx[idx]});
        ny     = $signed({2'b00, sh_y[idx]})
               + $signed({{(YW+2-VEL_W){sh_vy[idx][VEL_W-1]}}, sh_vy[idx]});
        nx_ref = nx;
        ny_ref = ny;
        vx_new = sh_vx[idx];
        vy_new = sh_vy[idx];
        if (nx[XW+1]) begin
            nx_ref = -nx;
            vx_new = -sh_vx[idx];
        end else if (nx > X_LIM) begin
            nx_ref = X_TWICE - nx;
            vx_new = -sh_vx[idx];
        end
        if (ny[YW+1]) begin
            ny_ref = -ny;
            vy_new = -sh_vy[idx];
        end else if (ny > Y_LIM) begin
            ny_ref = Y_TWICE - ny;
            vy_new = -sh_vy[idx];
        end
        x_new = nx_ref[XW-1:0];
        y_new = ny_ref[YW-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ticks outside IDLE are dropped, not queued.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (frame_tick && !freeze) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (idx == IDX_W'(NPTS - 1)) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shadow update, atomic commit and frame counter; reset reloads seeds everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < NPTS; i++) begin
                sh_x[i]             <= seed_x(i);
                sh_y[i]             <= seed_y(i);
                sh_vx[i]            <= seed_vx(i);
                sh_vy[i]            <= seed_vy(i);
                pts_x[i*XW +: XW]   <= seed_x(i);
                pts_y[i*YW +: YW]   <= seed_y(i);
            end
        end else begin
            case (state)
                ST_UPDATE: begin
                    sh_x[idx]  <= x_new;
                    sh_y[idx]  <= y_new;
                    sh_vx[idx] <= vx_new;
                    sh_vy[idx] <= vy_new;
                    idx        <= idx + 1'b1;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NPTS; i++) begin
                        pts_x[i*XW +: XW] <= sh_x[i];
                        pts_y[i*YW +: YW] <= sh_y[i];
                    end
                    frame_cnt <= frame_cnt + 20'd1;
                    idx       <= '0;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule
